// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants for the round-robin mux arbiter.
// State encodings, select values and default hold limit.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int MAX_HOLD_DEF = 4;
  localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Request/data/grant bundle between requesters and the arbiter.
// master: requesters (req_a/b, x_a/b); slave: arbiter (gnt_a/b, sel,
// m, valid, plus cnt_a/cnt_b when ARB_GRANT_CNT_EN is defined).
interface mux2_rr_arbiter_if;

  logic       req_a;
  logic       req_b;
  logic [1:0] x_a;
  logic [1:0] x_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       sel;
  logic [1:0] m;
  logic       valid;
`ifdef ARB_GRANT_CNT_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
`endif

  modport master (
    output req_a, req_b, x_a, x_b,
`ifdef ARB_GRANT_CNT_EN
    input  cnt_a, cnt_b,
`endif
    input  gnt_a, gnt_b, sel, m, valid
  );

  modport slave (
    input  req_a, req_b, x_a, x_b,
`ifdef ARB_GRANT_CNT_EN
    output cnt_a, cnt_b,
`endif
    output gnt_a, gnt_b, sel, m, valid
  );

endinterface

// File: rtl/mux2_rr_arbiter_mux2to1_2bit.sv
// 2-bit 2:1 mux: s=0 passes x, s=1 passes y.
// Ports: x, y (2-bit data), s (select), m (2-bit out).
module mux2to1_2bit (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       s,
  output logic [1:0] m
);

  assign m = s ? y : x;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing a 2-bit mux between requesters A and B.
// Ports: clock, reset (sync, active-high), bus (slave modport).
// Optional grant counters enabled by ARB_GRANT_CNT_EN.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  mux2_rr_arbiter_if.slave   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             entry_a, entry_b;
  logic             hold_done;
  logic [1:0]       mux_m;

  assign hold_done =
    (cnt_q >= CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    entry_a = 1'b0;
    entry_b = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Tie goes to whoever was not served last
        if (bus.req_a &&
            (!bus.req_b || last_q == SEL_B))
          entry_a = 1'b1;
        else if (bus.req_b)
          entry_b = 1'b1;
      end
      ST_GNT_A: begin
        if (bus.req_a && !hold_done)
          cnt_d = cnt_q + CNT_W'(1);
        else if (bus.req_b)
          entry_b = 1'b1;
        else if (bus.req_a)
          entry_a = 1'b1;
        else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_GNT_B: begin
        if (bus.req_b && !hold_done)
          cnt_d = cnt_q + CNT_W'(1);
        else if (bus.req_a)
          entry_a = 1'b1;
        else if (bus.req_b)
          entry_b = 1'b1;
        else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (entry_a) begin
      state_d = ST_GNT_A;
      cnt_d   = '0;
      last_d  = SEL_A;
      sel_d   = SEL_A;
    end
    if (entry_b) begin
      state_d = ST_GNT_B;
      cnt_d   = '0;
      last_d  = SEL_B;
      sel_d   = SEL_B;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= SEL_B;
      sel_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.gnt_a = (state_q == ST_GNT_A);
  assign bus.gnt_b = (state_q == ST_GNT_B);
  assign bus.valid = bus.gnt_a | bus.gnt_b;
  assign bus.sel   = sel_q;

  mux2to1_2bit u_mux (
    .x (bus.x_a),
    .y (bus.x_b),
    .s (sel_q),
    .m (mux_m)
  );

  assign bus.m = bus.valid ? mux_m : 2'b00;

`ifdef ARB_GRANT_CNT_EN
  logic [7:0] cnt_a_q, cnt_a_d;
  logic [7:0] cnt_b_q, cnt_b_d;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (entry_a && cnt_a_q != 8'hFF)
      cnt_a_d = cnt_a_q + 8'd1;
    if (entry_b && cnt_b_q != 8'hFF)
      cnt_b_d = cnt_b_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_a_q <= 8'd0;
      cnt_b_q <= 8'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter.
// Two instances: MAX_HOLD=4 and MAX_HOLD=1.
module tb_mux2_rr_arbiter;

  logic clock;
  logic reset;
  logic reset1;
  int   checks;
  int   errors;

  mux2_rr_arbiter_if if4 ();
  mux2_rr_arbiter_if if1 ();

  mux2_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (if4.slave)
  );

  mux2_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clock (clock),
    .reset (reset1),
    .bus   (if1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag,
                      input logic ga,
                      input logic gb,
                      input logic s,
                      input logic v,
                      input logic [1:0] mm);
    chk({tag, ".gnt_a"}, {7'd0, if4.gnt_a}, {7'd0, ga});
    chk({tag, ".gnt_b"}, {7'd0, if4.gnt_b}, {7'd0, gb});
    chk({tag, ".sel"}, {7'd0, if4.sel}, {7'd0, s});
    chk({tag, ".valid"}, {7'd0, if4.valid}, {7'd0, v});
    chk({tag, ".m"}, {6'd0, if4.m}, {6'd0, mm});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    reset1 = 1'b1;
    if4.req_a = 1'b1;
    if4.req_b = 1'b1;
    if4.x_a   = 2'b10;
    if4.x_b   = 2'b01;
    if1.req_a = 1'b1;
    if1.req_b = 1'b1;
    if1.x_a   = 2'b11;
    if1.x_b   = 2'b01;

    // Reset held with both requesting
    tick();
    tick();
    chk4("rst", 0, 0, 0, 0, 2'b00);
`ifdef ARB_GRANT_CNT_EN
    chk("rst.cnt_a", if1.cnt_a, 8'd0);
    chk("rst.cnt_b", if1.cnt_b, 8'd0);
`endif

    // First tie after reset goes to A
    reset = 1'b0;
    tick();
    chk4("first", 1, 0, 0, 1, 2'b10);

    // Continuous contention: A x4, B x4, A x4
    for (int i = 0; i < 12; i++) begin
      logic ea;
      ea = ((i / 4) % 2) == 0;
      chk4($sformatf("rr%0d", i), ea, !ea, !ea, 1,
           ea ? 2'b10 : 2'b01);
      chk("rr.excl", {7'd0, if4.gnt_a & if4.gnt_b},
          8'd0);
      if (i < 11) tick();
    end

    // A alone: re-grants after hold, no gap
    if4.req_b = 1'b0;
    tick();
    for (int j = 0; j < 8; j++) begin
      chk4($sformatf("solo%0d", j), 1, 0, 0, 1, 2'b10);
      if (j < 7) tick();
    end

    // Release to IDLE
    if4.req_a = 1'b0;
    tick();
    chk4("idle", 0, 0, 0, 0, 2'b00);

    // Handover at cycle 2 of an A grant
    if4.req_a = 1'b1;
    tick();
    chk4("ga1", 1, 0, 0, 1, 2'b10);
    tick();
    if4.req_a = 1'b0;
    if4.req_b = 1'b1;
    if4.x_b   = 2'b01;
    tick();
    chk4("hand", 0, 1, 1, 1, 2'b01);

    // Data passes with no clock edge
    if4.x_b = 2'b11;
    #1;
    chk("zlat.m", {6'd0, if4.m}, 8'h03);

    // sel holds its value in IDLE
    if4.req_b = 1'b0;
    tick();
    chk4("idle_b", 0, 0, 1, 0, 2'b00);

    // Reset mid B grant
    if4.req_b = 1'b1;
    tick();
    chk4("gb", 0, 1, 1, 1, 2'b11);
    reset = 1'b1;
    if4.req_a = 1'b1;
    tick();
    chk4("midrst", 0, 0, 0, 0, 2'b00);
    reset = 1'b0;
    tick();
    chk4("post", 1, 0, 0, 1, 2'b10);

    // MAX_HOLD=1: strict alternation, 300 grants
    reset1 = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      logic ea;
      ea = (i % 2) == 0;
      chk("alt.gnt_a", {7'd0, if1.gnt_a}, {7'd0, ea});
      chk("alt.gnt_b", {7'd0, if1.gnt_b}, {7'd0, !ea});
      chk("alt.m", {6'd0, if1.m},
          ea ? 8'h03 : 8'h01);
      if (i < 299) tick();
    end
`ifdef ARB_GRANT_CNT_EN
    chk("cnt_a150", if1.cnt_a, 8'd150);
    chk("cnt_b150", if1.cnt_b, 8'd150);
    for (int i = 0; i < 400; i++) tick();
    chk("cnt_a_sat", if1.cnt_a, 8'd255);
    chk("cnt_b_sat", if1.cnt_b, 8'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Round-robin arbiter that shares one 2-bit 2:1 mux channel between requesters A and B. It owns the select line and drives a registered grant FSM. The shared mux (mux2to1_2bit) passes the granted requester's 2-bit data to the output. It sits between board-level inputs (SW/KEY) and the LEDR display path. Each grant is bounded to MAX_HOLD cycles so neither requester can starve the other.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one grant may last; legal range 1..15.
CNT_W, 4, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_a  input  1  requester A wants the channel.
req_b  input  1  requester B wants the channel.
x_a  input  2  requester A data.
x_b  input  2  requester B data.
gnt_a  output  1  A owns the channel (registered).
gnt_b  output  1  B owns the channel (registered).
sel  output  1  mux select: 0 = A, 1 = B (registered).
m  output  2  channel data out.
valid  output  1  gnt_a | gnt_b.

Behaviour:
- Reset (synchronous, active-high; a sampled reset overrides all other inputs): state=IDLE, gnt_a=0, gnt_b=0, sel=0, valid=0, hold counter=0, last_served=B so that A wins the first tie.
- States: IDLE, GNT_A, GNT_B. Encoding is one-hot or binary. gnt_a/gnt_b decode directly from the state register.
- IDLE transitions:
  - req_a & req_b -> grant the requester that is not last_served.
  - Only req_a -> GNT_A.
  - Only req_b -> GNT_B.
  - Neither -> stay in IDLE.
- GNT_X (X = A or B):
  - Counter increments each cycle in the state.
  - Stay in GNT_X while req_x=1 and counter < MAX_HOLD-1.
  - Leave GNT_X when req_x drops or the counter reaches MAX_HOLD-1.
    - If the other requester is active, hand over to it.
    - Else, if req_x is still 1, re-grant X and reset the counter to 0.
    - Else go to IDLE.
- On every grant entry: counter=0 and last_served is updated.
- A direct handover A->B or B->A takes one edge, with no idle bubble.
- Latency: a request sampled at edge n gives a grant visible after edge n (cycle n+1). Release follows the same one-edge rule.
- sel=1 exactly when the state is GNT_B. In IDLE, sel holds its previous value.
- Datapath: m = valid ? mux2to1_2bit(x_a, x_b, sel) : 2'b00. The data path is combinational from the registered sel, so data changes pass through with zero latency.
- Invariants: gnt_a and gnt_b are never 1 together. valid never stays high for more than MAX_HOLD cycles without a grant-entry event.
- MAX_HOLD=1: every grant lasts one cycle. Under continuous requests from both sides, grants strictly alternate.
- Requests are level-sensitive and not latched. A request pulse that lands while the other requester holds the channel is lost.
- Reset mid-grant: on the next edge the block returns to IDLE with all outputs 0. Any in-flight ownership is dropped.

Optional Feature:
ARB_GRANT_CNT_EN:
- Defined: adds outputs cnt_a[7:0] and cnt_b[7:0].
  - Each increments by 1 on every grant-entry event for its requester, including a self re-grant after the hold limit.
  - Both saturate at 255.
  - Both reset to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/include file holds:
  - State encodings ST_IDLE, ST_GNT_A, ST_GNT_B.
  - Select constants SEL_A=0 and SEL_B=1.
  - Default MAX_HOLD.
- One sub-module: the existing mux2to1_2bit, instantiated once by name for the datapath.
- FSM and counter live inline in this block.

Test Plan:
- Reset with req_a=req_b=1 held -> all outputs 0 during reset. First edge after reset deasserts -> gnt_a=1, sel=0, m=x_a.
- req_a=1 only, x_a=2'b10, MAX_HOLD=4 -> gnt_a stays high; after 4 cycles it re-grants A (counter resets); m=2'b10 throughout.
- Both requesting continuously, MAX_HOLD=4 -> grant pattern A×4, B×4, A×4. sel toggles with no IDLE cycle between grants. gnt_a&gnt_b is never 1.
- In GNT_A at cycle 2, req_a drops and req_b=1 with x_b=2'b01 -> next cycle gnt_b=1, sel=1, m=2'b01.
- Reset asserted for 1 cycle during GNT_B -> next cycle state=IDLE, valid=0, m=2'b00. Next tie resolves to A.
- With ARB_GRANT_CNT_EN and 300 alternating grants (MAX_HOLD=1) -> cnt_a=cnt_b=150. Continued traffic -> both saturate at 255.
